// File: rtl/hazard_sequencer.sv
// hazard_sequencer
//   Pipeline stall/flush sequencer for the 5-stage core. It turns hazard
//   requests (load-use, taken branch/jump, multi-cycle mult/div) into
//   per-stage pipeline-register write enables, bubble-load controls and the
//   PC enable. It owns the MDU stall counter.
//
//   Parameters
//     MUL_LAT  total EX-stage cycles of a multiply (>= 1)
//     DIV_LAT  total EX-stage cycles of a divide (>= 1)
//     CNT_W    MDU counter width (>= clog2(max(MUL_LAT, DIV_LAT)))
//
//   Ports
//     clk          in   clock, rising edge
//     rst_n        in   asynchronous reset, active low
//     LoadUse      in   EX consumer depends on load in MEM
//     BranchTaken  in   control transfer taken in MEM
//     MduStart     in   mult/div instruction present in EX
//     MduIsDiv     in   1 = divide, 0 = multiply (valid with MduStart)
//     MidRegWrite  out  write enables [3]MEM/WB [2]EX/MEM [1]ID/EX [0]IF/ID
//     Stall        out  bubble-load per pipeline register, same bit order
//     Pcen         out  PC write enable
//     MduBusy      out  MDU op in progress (stalling)
//     MduDone      out  one-cycle pulse: MDU result valid in EX this cycle
//     StallCnt     out  (HAZ_PERF_EN only) saturating count of Pcen==0 cycles
//     FlushCnt     out  (HAZ_PERF_EN only) saturating count of branch flushes
//
//   Configuration macro: HAZ_PERF_EN adds the StallCnt/FlushCnt counters.
//
//   Outputs are combinational from state + inputs so the pipeline reacts in
//   the same cycle the hazard is detected.

module hazard_sequencer #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       LoadUse,
  input  logic       BranchTaken,
  input  logic       MduStart,
  input  logic       MduIsDiv,
  output logic [3:0] MidRegWrite,
  output logic [3:0] Stall,
  output logic       Pcen,
  output logic       MduBusy,
  output logic       MduDone
`ifdef HAZ_PERF_EN
  ,
  output logic [15:0] StallCnt,
  output logic [15:0] FlushCnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_HOLD  = 2'd1,
    MDU_WAIT = 2'd2
  } state_t;

  // The first waiting cycle is the start cycle itself, so the counter is
  // preloaded with L-2 and the done cycle is the one where it reads zero.
  localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LAT - 2);
  localparam logic             MUL_ONE  = (MUL_LAT == 1);
  localparam logic             DIV_ONE  = (DIV_LAT == 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r;
  state_t           nextState_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cntNext_s;
  logic [CNT_W-1:0] mduInit_s;
  logic             mduOne_s;
  logic             flush_s;

  // Latency selection; MduIsDiv matters only on the entry cycle.
  assign mduInit_s = MduIsDiv ? DIV_INIT : MUL_INIT;
  assign mduOne_s  = MduIsDiv ? DIV_ONE  : MUL_ONE;

  // State and MDU counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= nextState_s;
      cnt_r   <= cntNext_s;
    end
  end

  // Next-state logic and same-cycle pipeline controls.
  always_comb begin
    nextState_s = state_r;
    cntNext_s   = cnt_r;
    MidRegWrite = 4'b1111;
    Stall       = 4'b0000;
    Pcen        = 1'b1;
    MduBusy     = 1'b0;
    MduDone     = 1'b0;
    flush_s     = 1'b0;
    case (state_r)
      RUN, LU_HOLD: begin
        if (BranchTaken) begin
          // Flush kills IF/ID/EX, so the other requests belong to dead
          // instructions and are dropped.
          Stall       = 4'b0111;
          flush_s     = 1'b1;
          nextState_s = RUN;
        end else if (LoadUse && (state_r == RUN)) begin
          // In LU_HOLD the load has reached WB; a second stall would be
          // redundant, hence the state check.
          MidRegWrite = 4'b1100;
          Stall       = 4'b0100;
          Pcen        = 1'b0;
          nextState_s = LU_HOLD;
        end else if (MduStart) begin
          if (mduOne_s) begin
            MduDone     = 1'b1;
            nextState_s = RUN;
          end else begin
            MidRegWrite = 4'b1100;
            Stall       = 4'b0100;
            Pcen        = 1'b0;
            MduBusy     = 1'b1;
            cntNext_s   = mduInit_s;
            nextState_s = MDU_WAIT;
          end
        end else begin
          nextState_s = RUN;
        end
      end
      MDU_WAIT: begin
        // All requests are ignored here: MEM only holds bubbles, and the
        // MduStart seen in the done cycle is the op that is finishing.
        if (cnt_r != CNT_ZERO) begin
          MidRegWrite = 4'b1100;
          Stall       = 4'b0100;
          Pcen        = 1'b0;
          MduBusy     = 1'b1;
          cntNext_s   = cnt_r - CNT_ONE;
        end else begin
          MduDone     = 1'b1;
          nextState_s = RUN;
        end
      end
      default: begin
        nextState_s = RUN;
        cntNext_s   = CNT_ZERO;
      end
    endcase
  end

`ifdef HAZ_PERF_EN
  // Saturating performance counters for frozen-PC cycles and flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCnt <= 16'd0;
      FlushCnt <= 16'd0;
    end else begin
      if (!Pcen && (StallCnt != 16'hFFFF)) begin
        StallCnt <= StallCnt + 16'd1;
      end else begin
        StallCnt <= StallCnt;
      end
      if (flush_s && (FlushCnt != 16'hFFFF)) begin
        FlushCnt <= FlushCnt + 16'd1;
      end else begin
        FlushCnt <= FlushCnt;
      end
    end
  end
`else
  // Flush indication only feeds the performance counters.
  logic unusedFlush_s;
  assign unusedFlush_s = flush_s;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
module tb_hazard_sequencer;

  localparam int MUL_L = 4;
  localparam int DIV_L = 32;

  logic       clk;
  logic       rst_n;
  logic       LoadUse;
  logic       BranchTaken;
  logic       MduStart;
  logic       MduIsDiv;
  logic [3:0] MidRegWrite;
  logic [3:0] Stall;
  logic       Pcen;
  logic       MduBusy;
  logic       MduDone;
`ifdef HAZ_PERF_EN
  logic [15:0] StallCnt;
  logic [15:0] FlushCnt;
`endif

  hazard_sequencer #(.MUL_LAT(MUL_L), .DIV_LAT(DIV_L), .CNT_W(6)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .LoadUse(LoadUse),
    .BranchTaken(BranchTaken),
    .MduStart(MduStart),
    .MduIsDiv(MduIsDiv),
    .MidRegWrite(MidRegWrite),
    .Stall(Stall),
    .Pcen(Pcen),
    .MduBusy(MduBusy),
    .MduDone(MduDone)
`ifdef HAZ_PERF_EN
    ,
    .StallCnt(StallCnt),
    .FlushCnt(FlushCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] mrw;
    logic [3:0] stl;
    logic       pcen;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;
  int   checks = 0;
  int   errors = 0;

  // Reference model: cycle-number bookkeeping, not a state machine.
  longint cyc = 0;
  longint mduEnd = 0;
  bit     mduActive = 0;
  bit     luPrev = 0;
  int     stallM = 0;
  int     flushM = 0;

  function automatic exp_t mk(input logic [3:0] m, input logic [3:0] s,
                              input logic p, input logic b, input logic d);
    exp_t e;
    e.mrw = m; e.stl = s; e.pcen = p; e.busy = b; e.done = d;
    return e;
  endfunction

  task automatic modelStep(input logic bt, input logic lu, input logic ms,
                           input logic dv, output exp_t e);
    bit luNow;
    int lat;
    luNow = 0;
    lat = dv ? DIV_L : MUL_L;
    if (mduActive) begin
      if (cyc < mduEnd) e = mk(4'b1100, 4'b0100, 1'b0, 1'b1, 1'b0);
      else begin
        e = mk(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1);
        mduActive = 0;
      end
    end else if (bt) begin
      e = mk(4'b1111, 4'b0111, 1'b1, 1'b0, 1'b0);
      if (flushM < 65535) flushM++;
    end else if (lu && !luPrev) begin
      e = mk(4'b1100, 4'b0100, 1'b0, 1'b0, 1'b0);
      luNow = 1;
    end else if (ms) begin
      if (lat == 1) e = mk(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1);
      else begin
        e = mk(4'b1100, 4'b0100, 1'b0, 1'b1, 1'b0);
        mduActive = 1;
        mduEnd = cyc + lat - 1;
      end
    end else begin
      e = mk(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0);
    end
    luPrev = luNow;
    if (!e.pcen && stallM < 65535) stallM++;
    cyc++;
  endtask

  task automatic drive(input logic bt, input logic lu, input logic ms, input logic dv);
    exp_t e;
    @(posedge clk); #1;
    rst_n = 1'b1;
    BranchTaken = bt; LoadUse = lu; MduStart = ms; MduIsDiv = dv;
    modelStep(bt, lu, ms, dv, e);
    expQ.push_back(e);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must be RUN values at once.
  task automatic resetPulse();
    @(posedge clk); #1;
    BranchTaken = 1'b0; LoadUse = 1'b0; MduStart = 1'b0; MduIsDiv = 1'b0;
    rst_n = 1'b0;
    mduActive = 0; luPrev = 0; stallM = 0; flushM = 0;
    expQ.push_back(mk(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0));
  endtask

  task automatic divCount(input string name);
    int frozen;
    int dones;
    frozen = 0; dones = 0;
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    if (!Pcen) frozen++;
    if (MduDone) dones++;
    for (int i = 0; i < DIV_L + 2; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      if (!Pcen) frozen++;
      if (MduDone) dones++;
    end
    checks++;
    if (frozen != DIV_L - 1 || dones != 1) begin
      errors++;
      $display("FAIL %s frozen=%0d done=%0d required frozen=%0d done=1", name, frozen, dones, DIV_L - 1);
    end
  endtask

  // Scoreboard monitor: every cycle the DUT presents its controls.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      monE = expQ.pop_front();
      checks++;
      if ({MidRegWrite, Stall, Pcen, MduBusy, MduDone} !== monE) begin
        errors++;
        $display("FAIL ctrl t=%0t got mrw=%b stl=%b pcen=%b busy=%b done=%b required mrw=%b stl=%b pcen=%b busy=%b done=%b",
                 $time, MidRegWrite, Stall, Pcen, MduBusy, MduDone,
                 monE.mrw, monE.stl, monE.pcen, monE.busy, monE.done);
      end
    end
  end

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog time limit expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    BranchTaken = 1'b0; LoadUse = 1'b0; MduStart = 1'b0; MduIsDiv = 1'b0;
    #1;
    checks++;
    if ({MidRegWrite, Stall, Pcen, MduBusy, MduDone} !== 11'b1111_0000_100) begin
      errors++;
      $display("FAIL reset_state got %b required %b", {MidRegWrite, Stall, Pcen, MduBusy, MduDone}, 11'b1111_0000_100);
    end
    resetPulse();
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // Load-use held two cycles: one stall, then masked.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // Multiply held through its done cycle, then released.
    for (int i = 0; i < MUL_L; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // Divide: exact frozen-cycle count.
    divCount("div_frozen");

    // All requests at once: branch wins.
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // Load-use then multiply from LU_HOLD, branch ignored while waiting.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset at divide count 10, then a full-length divide again.
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    resetPulse();
    divCount("div_after_reset");

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) == 0));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);

`ifdef HAZ_PERF_EN
    @(posedge clk); #1;
    checks++;
    if (StallCnt !== 16'(stallM) || FlushCnt !== 16'(flushM)) begin
      errors++;
      $display("FAIL perf_random got %0d/%0d required %0d/%0d", StallCnt, FlushCnt, stallM, flushM);
    end
    resetPulse();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < DIV_L - 1; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (StallCnt !== 16'd93 || FlushCnt !== 16'd2) begin
      errors++;
      $display("FAIL perf_counts got %0d/%0d required 93/2", StallCnt, FlushCnt);
    end
    for (int k = 0; k < 2300; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < DIV_L - 1; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (StallCnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL perf_saturate got %h required ffff", StallCnt);
    end
`endif

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending required 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
